// File: rtl/pe_mac_q.sv
// Signed MAC processing element with rounded, saturated output and an upstream pass-through FIFO.
// Optional build macro PE_RELU_EN clips negative own results to zero after saturation.
module pe_mac_q #(
  parameter int DATA_W     = 8,
  parameter int ACC_W      = 24,
  parameter int OUT_W      = 16,
  parameter int CNT_W      = 11,
  parameter int SHIFT_W    = 5,
  parameter int PASS_DEPTH = 2
) (
  input  logic               clk_cal,
  input  logic               rst_cal_n,
  input  logic [DATA_W-1:0]  IMap,
  input  logic [DATA_W-1:0]  IWeight,
  input  logic               IMapVld,
  input  logic               IWeightVld,
  input  logic [CNT_W-1:0]   Calcycle,
  input  logic [SHIFT_W-1:0] IShift,
  input  logic [OUT_W-1:0]   INextPE_OMap,
  input  logic               INextPE_OMapVld,
  output logic [OUT_W-1:0]   OMap,
  output logic               OMapVld,
  output logic [DATA_W-1:0]  ONextPE_Map,
  output logic               ONextPE_MapVld,
  output logic               OOvf
);

  localparam int PROD_W = 2 * DATA_W;
  localparam int QW     = ACC_W + 1;
  localparam int PTR_W  = (PASS_DEPTH > 1) ? $clog2(PASS_DEPTH) : 1;
  localparam int FCNT_W = $clog2(PASS_DEPTH + 1);

  localparam logic signed [QW-1:0] SAT_MAX = {{(QW-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [QW-1:0] SAT_MIN = {{(QW-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

  // Valid semantics: every *Vld is a one-cycle qualifier with no back-pressure;
  // a beat is IMapVld & IWeightVld, a result is OMapVld for exactly one cycle.

  logic signed [ACC_W-1:0]  acc_q, acc_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d;
  logic [OUT_W-1:0]         omap_q, omap_d;
  logic                     omap_vld_q, omap_vld_d;
  logic [DATA_W-1:0]        fwd_map_q, fwd_map_d;
  logic                     fwd_vld_q, fwd_vld_d;
  logic                     ovf_q, ovf_d;

  logic [OUT_W-1:0]         fifo_q [PASS_DEPTH];
  logic [PTR_W-1:0]         rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]         wr_ptr_q, wr_ptr_d;
  logic [FCNT_W-1:0]        fcnt_q, fcnt_d;

  logic                     beat;
  logic signed [PROD_W-1:0] prod;
  logic signed [ACC_W-1:0]  prod_ext;
  logic signed [ACC_W-1:0]  sum;
  logic [CNT_W-1:0]         calc_last;
  logic                     final_beat;

  logic [QW-1:0]            rnd_v;
  logic signed [QW-1:0]     q_ext;
  logic signed [QW-1:0]     q_rnd;
  logic signed [QW-1:0]     q_shf;
  logic [OUT_W-1:0]         own_res;

  logic                     fifo_empty;
  logic                     fifo_full;
  logic                     pop;
  logic                     push_req;
  logic                     push;
  logic                     drop;
  logic                     direct;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(PASS_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Datapath: product, window end detection and accumulation.
  always_comb begin
    beat       = IMapVld & IWeightVld;
    prod       = $signed(IMap) * $signed(IWeight);
    prod_ext   = ACC_W'(prod);
    sum        = acc_q + prod_ext;
    calc_last  = (Calcycle == '0) ? '0 : Calcycle - 1'b1;
    final_beat = beat && (cnt_q >= calc_last);
    acc_d      = acc_q;
    cnt_d      = cnt_q;
    if (final_beat) begin
      acc_d = '0;
      cnt_d = '0;
    end else if (beat) begin
      acc_d = sum;
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Quantisation runs one bit wider than the accumulator so the rounding add cannot wrap.
  always_comb begin
    rnd_v = '0;
    if (IShift != '0) begin
      rnd_v = QW'(1) << (IShift - 1'b1);
    end
    q_ext = QW'(sum);
    q_rnd = q_ext + $signed(rnd_v);
    q_shf = q_rnd >>> IShift;
    if (q_shf > SAT_MAX) begin
      own_res = SAT_MAX[OUT_W-1:0];
    end else if (q_shf < SAT_MIN) begin
      own_res = SAT_MIN[OUT_W-1:0];
    end else begin
      own_res = q_shf[OUT_W-1:0];
    end
`ifdef PE_RELU_EN
    if (own_res[OUT_W-1]) begin
      own_res = '0;
    end
`endif
  end

  // Output arbitration: own result, then FIFO head, then a direct downstream value.
  always_comb begin
    fifo_empty = (fcnt_q == '0);
    fifo_full  = (fcnt_q == FCNT_W'(PASS_DEPTH));
    pop        = !final_beat && !fifo_empty;
    push_req   = INextPE_OMapVld && (final_beat || !fifo_empty);
    push       = push_req && (!fifo_full || pop);
    drop       = push_req && fifo_full && !pop;
    direct     = !final_beat && fifo_empty && INextPE_OMapVld;

    omap_d     = '0;
    omap_vld_d = 1'b0;
    if (final_beat) begin
      omap_d     = own_res;
      omap_vld_d = 1'b1;
    end else if (pop) begin
      omap_d     = fifo_q[rd_ptr_q];
      omap_vld_d = 1'b1;
    end else if (direct) begin
      omap_d     = INextPE_OMap;
      omap_vld_d = 1'b1;
    end

    rd_ptr_d = pop  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    wr_ptr_d = push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    fcnt_d   = fcnt_q + FCNT_W'(push) - FCNT_W'(pop);
    ovf_d    = ovf_q | drop;

    fwd_map_d = beat ? IMap : '0;
    fwd_vld_d = beat;
  end

  always_ff @(posedge clk_cal) begin
    if (!rst_cal_n) begin
      acc_q      <= '0;
      cnt_q      <= '0;
      omap_q     <= '0;
      omap_vld_q <= 1'b0;
      fwd_map_q  <= '0;
      fwd_vld_q  <= 1'b0;
      ovf_q      <= 1'b0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      fcnt_q     <= '0;
    end else begin
      acc_q      <= acc_d;
      cnt_q      <= cnt_d;
      omap_q     <= omap_d;
      omap_vld_q <= omap_vld_d;
      fwd_map_q  <= fwd_map_d;
      fwd_vld_q  <= fwd_vld_d;
      ovf_q      <= ovf_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      fcnt_q     <= fcnt_d;
    end
  end

  // Storage needs no reset: occupancy is tracked by fcnt_q.
  always_ff @(posedge clk_cal) begin
    if (push) begin
      fifo_q[wr_ptr_q] <= INextPE_OMap;
    end
  end

  assign OMap           = omap_q;
  assign OMapVld        = omap_vld_q;
  assign ONextPE_Map    = fwd_map_q;
  assign ONextPE_MapVld = fwd_vld_q;
  assign OOvf           = ovf_q;

endmodule

// File: tb/tb_pe_mac_q.sv
// Directed bench for pe_mac_q: per-cycle behavioural model comparison plus hand-computed expectations.
module tb_pe_mac_q;
  localparam int DATA_W     = 8;
  localparam int ACC_W      = 24;
  localparam int OUT_W      = 16;
  localparam int CNT_W      = 11;
  localparam int SHIFT_W    = 5;
  localparam int PASS_DEPTH = 2;

  logic               clk = 1'b0;
  logic               rst_n;
  logic [DATA_W-1:0]  imap, iwt;
  logic               map_vld, wt_vld;
  logic [CNT_W-1:0]   calcycle;
  logic [SHIFT_W-1:0] ishift;
  logic [OUT_W-1:0]   nmap;
  logic               nvld;
  logic [OUT_W-1:0]   omap;
  logic               omap_vld;
  logic [DATA_W-1:0]  fwd_map;
  logic               fwd_vld;
  logic               ovf;

  int checks = 0;
  int failures = 0;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  pe_mac_q #(
    .DATA_W(DATA_W), .ACC_W(ACC_W), .OUT_W(OUT_W),
    .CNT_W(CNT_W), .SHIFT_W(SHIFT_W), .PASS_DEPTH(PASS_DEPTH)
  ) dut (
    .clk_cal(clk),
    .rst_cal_n(rst_n),
    .IMap(imap),
    .IWeight(iwt),
    .IMapVld(map_vld),
    .IWeightVld(wt_vld),
    .Calcycle(calcycle),
    .IShift(ishift),
    .INextPE_OMap(nmap),
    .INextPE_OMapVld(nvld),
    .OMap(omap),
    .OMapVld(omap_vld),
    .ONextPE_Map(fwd_map),
    .ONextPE_MapVld(fwd_vld),
    .OOvf(ovf)
  );

  // ---------------- behavioural model ----------------
  longint         m_acc;
  int             m_cnt;
  logic [OUT_W-1:0] pass_q[$];
  logic [OUT_W-1:0] e_omap;
  logic           e_vld;
  logic [DATA_W-1:0] e_map;
  logic           e_mvld;
  logic           e_ovf;

  function automatic longint wrap_acc(input longint v);
    return (v <<< (64 - ACC_W)) >>> (64 - ACC_W);
  endfunction

  function automatic logic [OUT_W-1:0] quant(input longint s, input int sh);
    longint v;
    logic [63:0] bits;
    v = s;
    if (sh > 0) v = v + (longint'(1) <<< (sh - 1));
    v = v >>> sh;
    if (v > 32767) v = 32767;
    if (v < -32768) v = -32768;
`ifdef PE_RELU_EN
    if (v < 0) v = 0;
`endif
    bits = v;
    return bits[OUT_W-1:0];
  endfunction

  always @(posedge clk) begin
    longint p;
    int last;
    logic own;
    logic [OUT_W-1:0] res;
    if (!rst_n) begin
      m_acc = 0; m_cnt = 0; pass_q.delete();
      e_omap = '0; e_vld = 1'b0; e_map = '0; e_mvld = 1'b0; e_ovf = 1'b0;
    end else begin
      own = 1'b0;
      res = '0;
      if (map_vld && wt_vld) begin
        p = longint'($signed(imap)) * longint'($signed(iwt));
        last = (calcycle == 0) ? 0 : int'(calcycle) - 1;
        if (m_cnt >= last) begin
          res = quant(wrap_acc(m_acc + p), int'(ishift));
          own = 1'b1;
          m_acc = 0;
          m_cnt = 0;
        end else begin
          m_acc = wrap_acc(m_acc + p);
          m_cnt = m_cnt + 1;
        end
        e_map = imap; e_mvld = 1'b1;
      end else begin
        e_map = '0; e_mvld = 1'b0;
      end
      // An arrival joins the tail; it is accepted if a slot frees up this cycle.
      if (nvld) begin
        if (pass_q.size() < PASS_DEPTH || (!own && pass_q.size() > 0)) pass_q.push_back(nmap);
        else e_ovf = 1'b1;
      end
      if (own) begin
        e_omap = res; e_vld = 1'b1;
      end else if (pass_q.size() > 0) begin
        e_omap = pass_q.pop_front(); e_vld = 1'b1;
      end else begin
        e_omap = '0; e_vld = 1'b0;
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  task automatic cmp(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s at %0t: got=%h expected=%h", name, $time, got, exp);
    end
  endtask

  always @(posedge clk) begin
    #1;
    cmp("model_OMapVld", 32'(omap_vld), 32'(e_vld));
    cmp("model_OMap", 32'(omap), 32'(e_omap));
    cmp("model_ONextPE_MapVld", 32'(fwd_vld), 32'(e_mvld));
    cmp("model_ONextPE_Map", 32'(fwd_map), 32'(e_map));
    cmp("model_OOvf", 32'(ovf), 32'(e_ovf));
  end

  // ---------------- driver tasks ----------------
  task automatic step(input bit mv, input bit wv, input int m, input int w, input bit nv, input int n);
    @(negedge clk);
    map_vld = mv; wt_vld = wv;
    imap = m[DATA_W-1:0]; iwt = w[DATA_W-1:0];
    nvld = nv; nmap = n[OUT_W-1:0];
  endtask

  task automatic idle();
    step(0, 0, 0, 0, 0, 0);
  endtask

  task automatic beat(input int m, input int w);
    step(1, 1, m, w, 0, 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    map_vld = 0; wt_vld = 0; imap = '0; iwt = '0; nvld = 0; nmap = '0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Result must be visible one cycle after the final beat, for exactly one cycle.
  task automatic expect_result(input string name, input logic [OUT_W-1:0] exp);
    idle();
    cmp({name, "_vld"}, 32'(omap_vld), 32'd1);
    cmp(name, 32'(omap), 32'(exp));
    idle();
    cmp({name, "_vld_drop"}, 32'(omap_vld), 32'd0);
  endtask

  // ---------------- scoreboard / directed tests ----------------
  logic [OUT_W-1:0] exp_q[$];

  initial begin
    logic [OUT_W-1:0] neg7, negsat, neg3, neg6, neg3b;
`ifdef PE_RELU_EN
    neg7 = 16'h0000; negsat = 16'h0000; neg3 = 16'h0000; neg6 = 16'h0000; neg3b = 16'h0000;
`else
    neg7 = 16'hFFF9; negsat = 16'h8000; neg3 = 16'hFFFD; neg6 = 16'hFFFA; neg3b = 16'hFFFD;
`endif
    rst_n = 1'b0;
    map_vld = 0; wt_vld = 0; imap = '0; iwt = '0; nvld = 0; nmap = '0;
    calcycle = 11'd3; ishift = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    cmp("reset_OMap", 32'(omap), 32'd0);
    cmp("reset_OMapVld", 32'(omap_vld), 32'd0);
    cmp("reset_ONextPE_MapVld", 32'(fwd_vld), 32'd0);
    cmp("reset_OOvf", 32'(ovf), 32'd0);

    // Signed accumulate: 6 - 20 + 7 = -7
    calcycle = 11'd3; ishift = 5'd0;
    beat(2, 3); beat(-4, 5); beat(7, 1);
    expect_result("signed_acc", neg7);

    // Saturation and rounding: 4 * 16129 = 64516
    calcycle = 11'd4; ishift = 5'd0;
    repeat (4) beat(127, 127);
    expect_result("sat_pos", 16'h7FFF);
    ishift = 5'd2;
    repeat (4) beat(127, 127);
    expect_result("round_shift2", 16'h3F01);

    // Negative saturation: 3 * -16256 = -48768
    calcycle = 11'd3; ishift = 5'd0;
    repeat (3) beat(-128, 127);
    expect_result("sat_neg", negsat);

    // Round half up on a negative value: (-7 + 1) >>> 1 = -3
    calcycle = 11'd1; ishift = 5'd1;
    beat(-7, 1);
    expect_result("round_neg", neg3b);

    // Calcycle of 0 behaves as 1: -3 * 2 = -6
    calcycle = 11'd0; ishift = 5'd0;
    beat(-3, 2);
    expect_result("calcycle_zero", neg6);

    // Collision: own result first, downstream value one cycle later
    calcycle = 11'd1; ishift = 5'd0;
    step(1, 1, 3, 4, 1, 'h1234);
    idle();
    cmp("collide_own", 32'(omap), 32'd12);
    idle();
    cmp("collide_pass_vld", 32'(omap_vld), 32'd1);
    cmp("collide_pass", 32'(omap), 32'h1234);
    cmp("collide_ovf", 32'(ovf), 32'd0);

    // Idle downstream path: 1-cycle latency
    step(0, 0, 0, 0, 1, 'h0BEE);
    idle();
    cmp("direct_pass", 32'(omap), 32'h0BEE);

    // Bubbles and forwarding: 5*-3 + -2*-6 = -3
    calcycle = 11'd2;
    beat(5, -3);
    idle();
    cmp("fwd_map0", 32'(fwd_map), 32'h05);
    cmp("fwd_vld0", 32'(fwd_vld), 32'd1);
    step(1, 0, 9, 9, 0, 0);
    cmp("fwd_idle_map", 32'(fwd_map), 32'h00);
    cmp("fwd_idle_vld", 32'(fwd_vld), 32'd0);
    step(0, 1, 9, 9, 0, 0);
    cmp("half_valid_no_fwd", 32'(fwd_vld), 32'd0);
    beat(-2, -6);
    idle();
    cmp("fwd_map1", 32'(fwd_map), 32'hFE);
    cmp("bubble_result", 32'(omap), 32'(neg3));

    // Overflow: five own results, A and B queued behind them, C dropped
    calcycle = 11'd1;
    exp_q = '{16'd1, 16'd2, 16'd3, 16'd4, 16'd5, 16'h000A, 16'h000B};
    for (int k = 0; k < 10; k++) begin
      if (k < 5) step(1, 1, k + 1, 1, k < 3, 10 + k);
      else idle();
      if (k >= 1 && exp_q.size() > 0) begin
        cmp("ovf_seq_vld", 32'(omap_vld), 32'd1);
        cmp("ovf_seq", 32'(omap), 32'(exp_q.pop_front()));
      end
    end
    cmp("ovf_flag", 32'(ovf), 32'd1);
    cmp("ovf_drained", 32'(omap_vld), 32'd0);

    // Mid-window reset discards the partial sum
    calcycle = 11'd3;
    beat(10, 10);
    do_reset();
    cmp("rst_OMap", 32'(omap), 32'd0);
    cmp("rst_OMapVld", 32'(omap_vld), 32'd0);
    cmp("rst_fwd_map", 32'(fwd_map), 32'd0);
    cmp("rst_fwd_vld", 32'(fwd_vld), 32'd0);
    cmp("rst_ovf", 32'(ovf), 32'd0);
    beat(1, 2); beat(1, 3); beat(1, 4);
    expect_result("post_reset_sum", 16'h0009);

    repeat (3) idle();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pe_mac_q.md
# pe_mac_q

Parametrised signed MAC processing element for the systolic convolution array: accumulates `Calcycle` (= K·K·IChannel) products of input-map and weight pairs, then emits a rounded, saturated, optionally ReLU-clipped result. Forwards input-map values to the next PE with one-cycle delay. Carries results from downstream PEs up the column through a registered output port with a small pass-through FIFO, so a collision with its own result never loses data.

## Interface
- `DATA_W`, 8: IMap/IWeight width, two's complement.
- `ACC_W`, 24: accumulator width, at least 2·DATA_W.
- `OUT_W`, 16: result width, at most ACC_W.
- `CNT_W`, 11: width of `Calcycle` and the beat counter.
- `SHIFT_W`, 5: width of `IShift`.
- `PASS_DEPTH`, 2: pass-through FIFO depth, at least 1.

Ports:
- `clk_cal` in 1: clock. Single clock domain.
- `rst_cal_n` in 1: reset, synchronous, active-low.
- `IMap` in DATA_W: input-map operand.
- `IWeight` in DATA_W: weight operand.
- `IMapVld`, `IWeightVld` in 1 each: operand valids.
- `Calcycle` in CNT_W: beats per result. A value of 0 is treated as 1.
- `IShift` in SHIFT_W: output right-shift, from 0 to ACC_W−1.
- `INextPE_OMap` in OUT_W, `INextPE_OMapVld` in 1: result arriving from the downstream PE.
- `OMap` out OUT_W, `OMapVld` out 1: result sent to the upstream PE.
- `ONextPE_Map` out DATA_W, `ONextPE_MapVld` out 1: forwarded map value.
- `OOvf` out 1: sticky pass-through overflow flag.

## Operation
- A beat occurs when `IMapVld & IWeightVld` is high. No other cycle changes the accumulator or the beat counter.
- Product is the signed DATA_W × DATA_W multiply, 2·DATA_W bits, sign-extended to ACC_W.
- The accumulator adds modulo 2^ACC_W. It does not saturate internally.
- Non-final beat: acc += prod, cnt += 1.
- Final beat is when cnt ≥ Calcycle−1, so a `Calcycle` reduced mid-window ends the window immediately. On the final beat:
  - sum = acc + prod;
  - acc ← 0 and cnt ← 0;
  - the quantised sum is produced as the own result for this cycle.
- Quantisation, in order:
  - arithmetic right shift by `IShift`; when `IShift` > 0, add 2^(IShift−1) before shifting (round half up);
  - saturate to the signed OUT_W range [−2^(OUT_W−1), 2^(OUT_W−1)−1].
- Map forwarding: on a beat, register `IMap` and set `ONextPE_MapVld` to 1. Otherwise `ONextPE_Map` is 0 and `ONextPE_MapVld` is 0.
- Output register priority, evaluated each cycle:
  1. own result;
  2. FIFO head (pop);
  3. `INextPE_OMap` directly, when valid.
  - If none applies: `OMapVld` ← 0 and `OMap` ← 0.
- FIFO push: a valid `INextPE_OMap` is pushed when it cannot go straight to the output, i.e. an own result is present or the FIFO is non-empty. FIFO order is preserved.
- FIFO full:
  - a push with a simultaneous pop succeeds;
  - a push without a pop is dropped and sets `OOvf`. `OOvf` clears only on reset.

## Timing
- Reset, when `rst_cal_n` is low at a `clk_cal` edge, clears the following:
  - acc and cnt;
  - the FIFO (empty);
  - `OMap` = 0, `OMapVld` = 0;
  - `ONextPE_Map` = 0, `ONextPE_MapVld` = 0;
  - `OOvf` = 0.
- Reset in the middle of a window discards the partial sum. The next beat after reset is beat 0.
- Own result: `OMap` is valid in the cycle after the final beat. `OMapVld` is high for exactly one cycle per result.
- Downstream result with an idle path: 1-cycle latency.
- Downstream result delayed by k queued items: latency 1 + k cycles.
- `ONextPE_Map`: 1-cycle latency, so back-to-back beats give back-to-back forwarding.
- Gaps in beats pause the window and do not affect the result.
- `IShift` and `Calcycle` are sampled in the cycle of use.

## Configuration
- `PE_RELU_EN` defined: after saturation, negative results become 0. This applies to own results only; pass-through values are untouched.
- `PE_RELU_EN` undefined: signed results are output unchanged.

## Test plan
- Signed accumulate: `Calcycle`=3, `IShift`=0, pairs (2,3), (−4,5), (7,1).
  - `OMap`=0xFFF9 (−7) one cycle after the 3rd beat, `OMapVld` high for 1 cycle.
  - With `PE_RELU_EN`: `OMap`=0x0000.
- Saturation and rounding: `Calcycle`=4, four beats of (127,127), sum 64516.
  - `IShift`=0 gives `OMap`=0x7FFF.
  - `IShift`=2 gives 16129 (0x3F01).
- Collision: own final beat in cycle N with `INextPE_OMap`=0x1234 valid in cycle N.
  - Own result in cycle N+1; 0x1234 in cycle N+2; `OOvf`=0.
- Overflow: `Calcycle`=1 with continuous beats for 5 cycles, and `INextPE_OMap` = 0xA, 0xB, 0xC valid in the first 3 cycles (`PASS_DEPTH`=2).
  - 0xA and 0xB emerge after the own results, in that order.
  - 0xC is dropped and `OOvf`=1.
- Bubbles and forwarding: `Calcycle`=2, beats separated by 3 idle cycles.
  - The result is correct.
  - `ONextPE_Map` equals `IMap` one cycle after each beat and is 0 otherwise.
- Mid-window reset: `rst_cal_n` low for 1 cycle after beat 1 of 3.
  - All outputs read 0.
  - A fresh 3-beat window gives only the new sum.
